sensor_sample_scheduler: RTL and testbench
==========================================

// Module: sensor_sample_scheduler
// PURPOSE
//  Sequences the DHT11 reader and UART transmitter. Periodically triggers a DHT11 read,
//  waits for data, error or timeout, then frames the result into a 5-byte packet and
//  feeds it byte-by-byte to uart_tx. Also holds the last good temperature for the LED
//  threshold logic. Sits between dht11_reader and uart_tx in top.
// PARAMETERS
//  CLK_HZ            12_000_000  system clock frequency
//  SAMPLE_PERIOD_MS  2000        start-to-start interval between reads (DHT11 needs >=1 s)
//  TIMEOUT_MS        50          max wait for dht_valid/dht_error after dht_start
//  SYNC_BYTE         8'hAA       packet header byte
// PORTS
//  clk           in   1   system clock, rising edge
//  rst           in   1   asynchronous, active-high reset
//  enable        in   1   1 = periodic sampling runs; 0 = finish current packet, then idle
//  force_sample  in   1   1-cycle pulse: request an immediate read
//  dht_start     out  1   1-cycle pulse that starts dht11_reader
//  dht_valid     in   1   1-cycle pulse: dht_hum/dht_temp are valid
//  dht_error     in   1   1-cycle pulse: reader checksum/protocol failure
//  dht_hum       in   8   humidity, integer %RH
//  dht_temp      in   8   temperature, integer degC
//  uart_data     out  8   byte offered to uart_tx
//  uart_valid    out  1   uart_data is valid
//  uart_busy     in   1   uart_tx is shifting a byte
//  temp_latched  out  8   last good temperature (unchanged on error/timeout)
//  sample_count  out  16  completed packets sent, wraps 0xFFFF->0
//  err_count     out  8   errors + timeouts, saturates at 255
//  busy          out  1   1 whenever state != IDLE
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, period counter 0, pending flag 0, byte index 0.
//  - Period timer: counts clk cycles up to SAMPLE_PERIOD_MS*CLK_HZ/1000-1 while enable=1.
//    It restarts at 0 on every dht_start and is held at 0 while enable=0.
//  - Trigger request = period expiry OR force_sample. One pending flag only; a request
//    arriving when state != IDLE sets pending and is not dropped. Extra requests while
//    pending=1 merge into it.
//  - States: IDLE -> TRIGGER -> WAIT_DATA -> SEND -> GAP -> SEND ... -> IDLE.
//    IDLE: on a request or pending (and enable=1, or force_sample), go to TRIGGER and
//          clear pending.
//    TRIGGER: dht_start=1 for exactly this cycle; go to WAIT_DATA.
//    WAIT_DATA: on dht_valid, capture hum/temp with status=0x00 and update temp_latched.
//          On dht_error, status=0x01. If TIMEOUT_MS elapses with neither, status=0x02.
//          Error/timeout: hum=temp=0 in the packet and err_count++ (saturating).
//          If dht_valid and dht_error arrive in the same cycle, dht_error wins.
//          All three cases then go to SEND with index=0.
//    SEND: uart_valid=1 and uart_data=pkt[index], held stable. A byte is accepted on the
//          first cycle with uart_valid=1 and uart_busy=0; go to GAP on the next edge.
//    GAP: uart_valid=0 for exactly 2 cycles, which covers uart_tx busy-rise latency. Then,
//          if index<4, increment index and return to SEND. Otherwise sample_count++ and
//          go to IDLE.
//  - Packet: [0]=SYNC_BYTE, [1]=hum, [2]=temp, [3]=status,
//    [4]=chk=(hum+temp+status) mod 256 (8-bit wrap).
//  - enable falling mid-packet: the packet completes. No new trigger until enable=1 or
//    force_sample.
//  - Async rst mid-packet: the transfer aborts immediately, uart_valid=0, and no partial
//    count is kept.
// STRUCTURE
//  - sensor_pkg: state enum (IDLE, TRIGGER, WAIT_DATA, SEND, GAP), PKT_LEN=5,
//    STATUS_OK/ERR/TIMEOUT constants, byte index width.
//  - Sub-module period_timer (cycle counter, restart, hold, expiry pulse). It is
//    instantiated twice: once for the sample period and once for the timeout.
// TESTING (CLK_HZ=1000, SAMPLE_PERIOD_MS=20, TIMEOUT_MS=5; BFM uart: busy 1 cycle after
//          accept, for 10 cycles)
//  1. enable=1, reader returns hum=0x2D, temp=0x19
//     -> dht_start every 20 cycles; bytes AA 2D 19 00 46; temp_latched=0x19;
//        sample_count=1.
//  2. reader silent after dht_start
//     -> timeout after 5 cycles; bytes AA 00 00 02 02; err_count=1; temp_latched
//        unchanged.
//  3. dht_valid and dht_error in the same cycle
//     -> status 0x01 is sent and temp_latched is not updated.
//  4. force_sample during SEND
//     -> pending set; a new dht_start follows the current packet's return to IDLE;
//        no request is lost.
//  5. hum=0xF0, temp=0x20 -> chk=0x10 (wrap); 256 forced errors -> err_count stays 0xFF.
//  6. rst pulse while SEND index=2 -> uart_valid=0 and all counters 0 immediately; after
//     release, the next packet starts from SYNC_BYTE.

Source files
------------

// File: rtl/sensor_pkg.sv
// Shared types and constants for the sensor sample scheduler.
//   state_e       : scheduler FSM states
//   PktLen/IdxW   : packet length and byte-index width
//   Status*       : status byte values carried in packet byte 3
//   pkt_checksum  : 8-bit wrapping sum of hum, temp and status
package sensor_pkg;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StTrigger  = 3'd1,
    StWaitData = 3'd2,
    StSend     = 3'd3,
    StGap      = 3'd4
  } state_e;

  localparam int unsigned PktLen = 5;
  localparam int unsigned IdxW   = $clog2(PktLen);

  localparam logic [7:0] StatusOk      = 8'h00;
  localparam logic [7:0] StatusErr     = 8'h01;
  localparam logic [7:0] StatusTimeout = 8'h02;

  function automatic logic [7:0] pkt_checksum(input logic [7:0] hum,
                                              input logic [7:0] temp,
                                              input logic [7:0] status);
    return hum + temp + status;
  endfunction

endpackage

// File: rtl/period_timer.sv
// Free-running cycle counter with synchronous restart and hold.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_run        : count enable; the counter holds its value while low
//   i_restart    : force the count back to 0 (wins over i_run)
//   o_expire     : high during the cycle the count sits at Limit-1 while running
module period_timer #(
  parameter int unsigned Limit = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_run,
  input  logic i_restart,
  output logic o_expire
);

  localparam int unsigned CntW = (Limit > 1) ? $clog2(Limit) : 1;
  localparam logic [CntW-1:0] LastVal = CntW'(Limit - 1);

  logic [CntW-1:0] r_count;
  logic            w_at_last;

  assign w_at_last = (r_count == LastVal);
  // Independent of i_restart so the expiry can feed the restart decision without a loop.
  assign o_expire  = i_run & w_at_last;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_restart) begin
      r_count <= '0;
    end else if (i_run) begin
      r_count <= w_at_last ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/sensor_sample_scheduler.sv
// Sequences DHT11 reads and frames each result as a 5-byte UART packet:
//   [SYNC_BYTE, hum, temp, status, chk]
// Ports:
//   i_clk, i_rst        : clock, asynchronous active-high reset
//   i_enable            : periodic sampling enable
//   i_force_sample      : one-cycle request for an immediate read
//   o_dht_start         : one-cycle start pulse to the reader
//   i_dht_valid/error   : reader result pulses; i_dht_hum/temp valid with i_dht_valid
//   o_uart_data/valid   : byte offered to the UART, i_uart_busy back-pressure
//   o_temp_latched      : last good temperature
//   o_sample_count      : packets completed (wrapping)
//   o_err_count         : errors plus timeouts (saturating)
//   o_busy              : scheduler not idle
module sensor_sample_scheduler
  import sensor_pkg::*;
#(
  parameter int unsigned CLK_HZ           = 12_000_000,
  parameter int unsigned SAMPLE_PERIOD_MS = 2000,
  parameter int unsigned TIMEOUT_MS       = 50,
  parameter logic [7:0]  SYNC_BYTE        = 8'hAA
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_enable,
  input  logic        i_force_sample,
  output logic        o_dht_start,
  input  logic        i_dht_valid,
  input  logic        i_dht_error,
  input  logic [7:0]  i_dht_hum,
  input  logic [7:0]  i_dht_temp,
  output logic [7:0]  o_uart_data,
  output logic        o_uart_valid,
  input  logic        i_uart_busy,
  output logic [7:0]  o_temp_latched,
  output logic [15:0] o_sample_count,
  output logic [7:0]  o_err_count,
  output logic        o_busy
);

  // 64-bit intermediate: period_ms * clk_hz overflows 32 bits at real clock rates.
  localparam int unsigned PeriodCycles =
    32'((64'(SAMPLE_PERIOD_MS) * 64'(CLK_HZ)) / 64'd1000);
  localparam int unsigned TimeoutCycles =
    32'((64'(TIMEOUT_MS) * 64'(CLK_HZ)) / 64'd1000);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(PktLen - 1);

  state_e          r_state, w_state_next;
  logic            r_pending;
  logic [IdxW-1:0] r_idx;
  logic            r_gap;
  logic [7:0]      r_hum, r_temp, r_status;
  logic [7:0]      r_temp_latched, r_err_count;
  logic [15:0]     r_sample_count;

  logic       w_period_exp, w_timeout, w_go, w_last_byte, w_gap_done;
  logic [7:0] w_chk, w_pkt_byte;

  assign w_go = (r_state == StIdle) &
                (i_force_sample | (i_enable & (w_period_exp | r_pending)));
  assign w_last_byte = (r_idx == LastIdx);
  assign w_gap_done  = (r_state == StGap) & r_gap;
  assign w_chk       = pkt_checksum(r_hum, r_temp, r_status);

  // Sample period: held at 0 while disabled, restarted as the FSM heads into TRIGGER
  // so the count reads 0 on the dht_start cycle.
  period_timer #(
    .Limit(PeriodCycles)
  ) u_period (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_run    (i_enable),
    .i_restart(w_go | ~i_enable),
    .o_expire (w_period_exp)
  );

  period_timer #(
    .Limit(TimeoutCycles)
  ) u_timeout (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_run    (r_state == StWaitData),
    .i_restart(r_state != StWaitData),
    .o_expire (w_timeout)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:     if (w_go) w_state_next = StTrigger;
      StTrigger:  w_state_next = StWaitData;
      StWaitData: if (i_dht_valid | i_dht_error | w_timeout) w_state_next = StSend;
      StSend:     if (!i_uart_busy) w_state_next = StGap;
      StGap:      if (r_gap) w_state_next = w_last_byte ? StIdle : StSend;
      default:    w_state_next = StIdle;
    endcase
  end

  always_comb begin
    o_dht_start  = 1'b0;
    o_uart_valid = 1'b0;
    o_uart_data  = '0;
    unique case (r_state)
      StTrigger: o_dht_start = 1'b1;
      StSend: begin
        o_uart_valid = 1'b1;
        o_uart_data  = w_pkt_byte;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_pkt_byte = w_chk;
    case (r_idx)
      IdxW'(0): w_pkt_byte = SYNC_BYTE;
      IdxW'(1): w_pkt_byte = r_hum;
      IdxW'(2): w_pkt_byte = r_temp;
      IdxW'(3): w_pkt_byte = r_status;
      default:  w_pkt_byte = w_chk;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pending      <= 1'b0;
      r_idx          <= '0;
      r_gap          <= 1'b0;
      r_hum          <= '0;
      r_temp         <= '0;
      r_status       <= '0;
      r_temp_latched <= '0;
      r_err_count    <= '0;
      r_sample_count <= '0;
    end else begin
      // Single pending slot: requests while busy merge into it.
      if (w_go) begin
        r_pending <= 1'b0;
      end else if ((w_period_exp | i_force_sample) && (r_state != StIdle)) begin
        r_pending <= 1'b1;
      end

      if (r_state == StWaitData) begin
        r_idx <= '0;
        // Error beats valid when both pulse together.
        if (i_dht_error || (w_timeout && !i_dht_valid)) begin
          r_hum    <= '0;
          r_temp   <= '0;
          r_status <= i_dht_error ? StatusErr : StatusTimeout;
          if (r_err_count != 8'hFF) r_err_count <= r_err_count + 8'd1;
        end else if (i_dht_valid) begin
          r_hum          <= i_dht_hum;
          r_temp         <= i_dht_temp;
          r_status       <= StatusOk;
          r_temp_latched <= i_dht_temp;
        end
      end

      // Two-cycle gap: r_gap marks the second cycle.
      r_gap <= (r_state == StGap) & ~r_gap;

      if (w_gap_done) begin
        if (w_last_byte) begin
          r_sample_count <= r_sample_count + 16'd1;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end
    end
  end

  assign o_temp_latched = r_temp_latched;
  assign o_sample_count = r_sample_count;
  assign o_err_count    = r_err_count;
  assign o_busy         = (r_state != StIdle);

endmodule

// File: tb/tb_sensor_sample_scheduler.sv
module tb_sensor_sample_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        enable = 1'b0;
  logic        force_sample = 1'b0;
  logic        dht_start;
  logic        dht_valid = 1'b0;
  logic        dht_error = 1'b0;
  logic [7:0]  dht_hum = 8'h00;
  logic [7:0]  dht_temp = 8'h00;
  logic [7:0]  uart_data;
  logic        uart_valid;
  logic        uart_busy = 1'b0;
  logic [7:0]  temp_latched;
  logic [15:0] sample_count;
  logic [7:0]  err_count;
  logic        busy;

  always #5 clk = ~clk;

  sensor_sample_scheduler #(
    .CLK_HZ          (1000),
    .SAMPLE_PERIOD_MS(20),
    .TIMEOUT_MS      (5),
    .SYNC_BYTE       (8'hAA)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_enable      (enable),
    .i_force_sample(force_sample),
    .o_dht_start   (dht_start),
    .i_dht_valid   (dht_valid),
    .i_dht_error   (dht_error),
    .i_dht_hum     (dht_hum),
    .i_dht_temp    (dht_temp),
    .o_uart_data   (uart_data),
    .o_uart_valid  (uart_valid),
    .i_uart_busy   (uart_busy),
    .o_temp_latched(temp_latched),
    .o_sample_count(sample_count),
    .o_err_count   (err_count),
    .o_busy        (busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reader model: answers one cycle into WAIT_DATA. Modes: 0 ok, 1 error, 2 silent, 3 both.
  int         dht_mode = 0;
  logic [7:0] cfg_hum = 8'h00;
  logic [7:0] cfg_temp = 8'h00;
  int         n_starts = 0;
  int         n_dbl = 0;
  int         t_start = 0;
  int         dcnt = 0;
  logic       prev_start = 1'b0;

  always @(negedge clk) begin
    dht_valid = 1'b0;
    dht_error = 1'b0;
    if (rst) begin
      dcnt = 0;
      prev_start = 1'b0;
    end else begin
      if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) begin
          dht_hum   = cfg_hum;
          dht_temp  = cfg_temp;
          dht_valid = (dht_mode == 0) || (dht_mode == 3);
          dht_error = (dht_mode == 1) || (dht_mode == 3);
        end
      end
      if (dht_start) begin
        n_starts++;
        t_start = cyc;
        if (prev_start) n_dbl++;
        dcnt = 1;
      end
      prev_start = dht_start;
    end
  end

  // UART model: busy rises one cycle after accept and stays high for 10 cycles.
  logic [7:0] q_bytes[$];
  int         ucnt = 0;
  int         n_unstable = 0;
  logic       prev_uv = 1'b0;
  logic [7:0] prev_ud = 8'h00;

  always @(negedge clk) begin
    if (rst) begin
      ucnt = 0;
      uart_busy = 1'b0;
      prev_uv = 1'b0;
    end else begin
      if (uart_valid && prev_uv && (uart_data != prev_ud)) n_unstable++;
      prev_uv = uart_valid;
      prev_ud = uart_data;
      if (ucnt > 0) ucnt--;
      uart_busy = (ucnt >= 1) && (ucnt <= 10);
      if (uart_valid && !uart_busy && (ucnt == 0)) begin
        q_bytes.push_back(uart_data);
        ucnt = 12;
      end
    end
  end

  int n_vec = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] byte_at(input int i);
    if (i < q_bytes.size()) return {8'h00, q_bytes[i]};
    return 16'hFFFF;
  endfunction

  task automatic wait_bytes(input int n, input int budget);
    int k = 0;
    while ((q_bytes.size() < n) && (k < budget)) begin
      @(negedge clk);
      k++;
    end
    if (q_bytes.size() < n) begin
      n_vec++;
      n_fail++;
      $display("FAIL wait_bytes: got %0d bytes, expected %0d", q_bytes.size(), n);
    end
  endtask

  task automatic wait_starts(input int n, input int budget);
    int k = 0;
    while ((n_starts < n) && (k < budget)) begin
      @(negedge clk);
      k++;
    end
    if (n_starts < n) begin
      n_vec++;
      n_fail++;
      $display("FAIL wait_starts: got %0d starts, expected %0d", n_starts, n);
    end
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    @(negedge clk);
    while (busy && (k < budget)) begin
      @(negedge clk);
      k++;
    end
    if (busy) begin
      n_vec++;
      n_fail++;
      $display("FAIL wait_idle: busy got 1, expected 0");
    end
  endtask

  task automatic wait_valid(input int budget);
    int k = 0;
    while (!uart_valid && (k < budget)) begin
      @(negedge clk);
      k++;
    end
    if (!uart_valid) begin
      n_vec++;
      n_fail++;
      $display("FAIL wait_valid: uart_valid got 0, expected 1");
    end
  endtask

  task automatic pulse_force();
    @(negedge clk);
    force_sample = 1'b1;
    @(negedge clk);
    force_sample = 1'b0;
  endtask

  task automatic check_pkt(input string tag, input int base, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4);
    check($sformatf("%s byte0", tag), byte_at(base),     16'h00AA);
    check($sformatf("%s byte1", tag), byte_at(base + 1), {8'h00, b1});
    check($sformatf("%s byte2", tag), byte_at(base + 2), {8'h00, b2});
    check($sformatf("%s byte3", tag), byte_at(base + 3), {8'h00, b3});
    check($sformatf("%s byte4", tag), byte_at(base + 4), {8'h00, b4});
  endtask

  typedef struct {
    int          mode;
    logic [7:0]  hum;
    logic [7:0]  temp;
    logic [7:0]  b1, b2, b3, b4;
    logic [7:0]  latched;
    logic [7:0]  errc;
    logic [15:0] scnt;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int base;
    int base_s;
    int t0;

    vecs[0] = '{2, 8'h11, 8'h22, 8'h00, 8'h00, 8'h02, 8'h02, 8'h19, 8'd1, 16'd3};
    vecs[1] = '{3, 8'h40, 8'h22, 8'h00, 8'h00, 8'h01, 8'h01, 8'h19, 8'd2, 16'd4};
    vecs[2] = '{1, 8'h55, 8'h66, 8'h00, 8'h00, 8'h01, 8'h01, 8'h19, 8'd3, 16'd5};
    vecs[3] = '{0, 8'hF0, 8'h20, 8'hF0, 8'h20, 8'h00, 8'h10, 8'h20, 8'd3, 16'd6};
    vecs[4] = '{0, 8'h7F, 8'h85, 8'h7F, 8'h85, 8'h00, 8'h04, 8'h85, 8'd3, 16'd7};

    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset uart_valid", {15'd0, uart_valid}, 16'd0);
    check("reset uart_data", {8'd0, uart_data}, 16'd0);
    check("reset dht_start", {15'd0, dht_start}, 16'd0);
    check("reset temp_latched", {8'd0, temp_latched}, 16'd0);
    check("reset sample_count", sample_count, 16'd0);
    check("reset err_count", {8'd0, err_count}, 16'd0);
    check("reset busy", {15'd0, busy}, 16'd0);

    // Periodic sampling: first start 20 cycles after enable, pending re-trigger afterwards.
    dht_mode = 0;
    cfg_hum  = 8'h2D;
    cfg_temp = 8'h19;
    @(negedge clk);
    rst    = 1'b0;
    enable = 1'b1;
    t0     = cyc;
    wait_starts(1, 40);
    check("first start delay", 16'(t_start - t0), 16'd20);
    wait_bytes(5, 200);
    check_pkt("periodic pkt1", 0, 8'h2D, 8'h19, 8'h00, 8'h46);
    wait_starts(2, 100);
    enable = 1'b0;
    check("periodic sample_count", sample_count, 16'd1);
    check("periodic temp_latched", {8'd0, temp_latched}, 16'h0019);
    check("periodic err_count", {8'd0, err_count}, 16'd0);
    wait_bytes(10, 200);
    check_pkt("disable mid-pkt", 5, 8'h2D, 8'h19, 8'h00, 8'h46);
    wait_idle(50);
    check("disable sample_count", sample_count, 16'd2);
    repeat (60) @(negedge clk);
    check("no start while disabled", 16'(n_starts), 16'd2);
    check("idle while disabled", {15'd0, busy}, 16'd0);

    // Table of forced reads.
    for (int v = 0; v < 5; v++) begin
      dht_mode = vecs[v].mode;
      cfg_hum  = vecs[v].hum;
      cfg_temp = vecs[v].temp;
      base = q_bytes.size();
      pulse_force();
      wait_bytes(base + 5, 200);
      check_pkt($sformatf("vec%0d", v), base, vecs[v].b1, vecs[v].b2, vecs[v].b3,
                vecs[v].b4);
      wait_idle(50);
      check($sformatf("vec%0d temp_latched", v), {8'd0, temp_latched},
            {8'd0, vecs[v].latched});
      check($sformatf("vec%0d err_count", v), {8'd0, err_count}, {8'd0, vecs[v].errc});
      check($sformatf("vec%0d sample_count", v), sample_count, vecs[v].scnt);
    end

    // Force during SEND plus period expiries merge into exactly one extra read.
    dht_mode = 0;
    cfg_hum  = 8'h11;
    cfg_temp = 8'h22;
    base   = q_bytes.size();
    base_s = n_starts;
    @(negedge clk);
    enable       = 1'b1;
    force_sample = 1'b1;
    @(negedge clk);
    force_sample = 1'b0;
    wait_valid(50);
    force_sample = 1'b1;
    @(negedge clk);
    force_sample = 1'b0;
    wait_bytes(base + 5, 200);
    wait_starts(base_s + 2, 100);
    enable = 1'b0;
    wait_bytes(base + 10, 200);
    wait_idle(50);
    repeat (60) @(negedge clk);
    check("merged request starts", 16'(n_starts - base_s), 16'd2);
    check_pkt("pending pkt1", base, 8'h11, 8'h22, 8'h00, 8'h33);
    check_pkt("pending pkt2", base + 5, 8'h11, 8'h22, 8'h00, 8'h33);
    check("pending sample_count", sample_count, 16'd9);

    // Error counter saturation.
    dht_mode = 1;
    for (int i = 0; i < 256; i++) begin
      base = q_bytes.size();
      pulse_force();
      wait_bytes(base + 5, 200);
      wait_idle(50);
      if (i == 251) check("err_count reaches 255", {8'd0, err_count}, 16'h00FF);
    end
    check("err_count saturated", {8'd0, err_count}, 16'h00FF);
    check("sample_count after errors", sample_count, 16'd265);
    check("last error status", byte_at(q_bytes.size() - 2), 16'h0001);

    // Asynchronous reset in the middle of byte index 2.
    dht_mode = 0;
    cfg_hum  = 8'h2D;
    cfg_temp = 8'h19;
    base = q_bytes.size();
    pulse_force();
    wait_bytes(base + 2, 200);
    wait_valid(50);
    check("byte2 before reset", {8'd0, uart_data}, 16'h0019);
    #2 rst = 1'b1;
    #1;
    check("async rst uart_valid", {15'd0, uart_valid}, 16'd0);
    check("async rst busy", {15'd0, busy}, 16'd0);
    check("async rst sample_count", sample_count, 16'd0);
    check("async rst err_count", {8'd0, err_count}, 16'd0);
    check("async rst temp_latched", {8'd0, temp_latched}, 16'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("aborted pkt bytes", 16'(q_bytes.size() - base), 16'd2);
    base = q_bytes.size();
    pulse_force();
    wait_bytes(base + 5, 200);
    check_pkt("post-reset pkt", base, 8'h2D, 8'h19, 8'h00, 8'h46);
    wait_idle(50);
    check("post-reset sample_count", sample_count, 16'd1);
    check("post-reset temp_latched", {8'd0, temp_latched}, 16'h0019);

    check("dht_start single cycle", 16'(n_dbl), 16'd0);
    check("uart_data held while valid", 16'(n_unstable), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
